dmem_arbiter: RTL and testbench

- Two-port controller in front of the single-port data memory (128 x 32-bit words, byte address [8:0], word index addr[8:2]).
- Port 0 is the CPU load/store unit; port 1 is the debug/loader port.
- Sequences one memory transaction at a time, with a fixed three-cycle IDLE->CMD->RESP sequence.
- Drives the memory's MemRead/MemWrite strobes, checks alignment, and returns response data and error to the winning requester.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arb_pick.sv | 25 ++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The optional round-robin tie-break is selected with `DMEM_ARB_RR_EN`.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word accesses must have the two low byte-address bits clear.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way picker.
// With mode=1 a tie goes to the port that was not granted last.
// With mode=0 a tie always goes to the CPU port.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic       winner,
  output logic       valid
);

  // Select a winner from the current request vector.
  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = mode ? ~last : PORT_CPU;
    end else if (req == 2'b10) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 is the CPU load/store unit and port 1 is the debug/loader port.
// Each transaction takes exactly three cycles: IDLE -> CMD -> RESP.
// Define `DMEM_ARB_RR_EN` for a round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic pick_id;
  logic pick_vld;
  logic aligned;

  dmem_arb_pick u_pick (
    .req    ({p1_req, p0_req}),
    .last   (last_q),
    .mode   (RR_MODE),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  assign aligned  = is_aligned(addr_q[1:0]);
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

  // State and the latched transaction; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= PORT_DBG;
      id_q       <= PORT_CPU;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Next-state logic and the per-state output decode.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    p0_done    = 1'b0;
    p1_done    = 1'b0;
    p0_err     = 1'b0;
    p1_err     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        // The request is sampled only here; later changes on the inputs are ignored.
        if (pick_vld) begin
          id_d    = pick_id;
          we_d    = pick_id ? p1_we    : p0_we;
          addr_d  = pick_id ? p1_addr  : p0_addr;
          wdata_d = pick_id ? p1_wdata : p0_wdata;
          state_d = CMD;
        end
      end

      CMD: begin
        p0_gnt    = (id_q == PORT_CPU);
        p1_gnt    = (id_q == PORT_DBG);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        // A misaligned access never touches the memory.
        MemWrite  = aligned & we_q;
        MemRead   = aligned & ~we_q;
        last_d    = id_q;
        err_d     = ~aligned;
        // Read data is captured here; writes and errors return zero.
        if (id_q == PORT_DBG) begin
          p1_rdata_d = (aligned && !we_q) ? mem_rdata : '0;
        end else begin
          p0_rdata_d = (aligned && !we_q) ? mem_rdata : '0;
        end
        state_d   = RESP;
      end

      RESP: begin
        p0_done = (id_q == PORT_CPU);
        p1_done = (id_q == PORT_DBG);
        p0_err  = (id_q == PORT_CPU) & err_q;
        p1_err  = (id_q == PORT_DBG) & err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses come from a word-array model.
module tb_dmem_arbiter;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [8:0]  p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        MemRead, MemWrite;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic        pl_en = 0;
  logic [6:0]  pl_idx = 0;
  logic [31:0] pl_val = 0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory that the DUT drives: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (MemWrite) mem[mem_addr[8:2]] <= mem_wdata;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Expected response of one transaction, from the memory-model rules.
  function automatic exp_t model(input int port, input bit we, input logic [8:0] addr,
                                 input logic [31:0] wd);
    exp_t e;
    e.port = port;
    e.err = 1'b0;
    e.rdata = 32'h0;
    if (addr[1:0] != 2'b00) e.err = 1'b1;
    else if (we) ref_mem[addr[8:2]] = wd;
    else e.rdata = ref_mem[addr[8:2]];
    return e;
  endfunction

  // Monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    if (rst_n && (p0_done || p1_done)) begin
      chk("done_onehot", 32'(p0_done & p1_done), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(p1_done), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", 32'(p1_done), 32'(e.port));
        chk("done_err", 32'(p1_done ? p1_err : p0_err), 32'(e.err));
        chk("done_rdata", p1_done ? p1_rdata : p0_rdata, e.rdata);
      end
    end
    if (MemRead || MemWrite) chk("strobe_excl", 32'(MemRead & MemWrite), 32'd0);
  end

  // One transaction on one port, starting and ending at a falling edge in IDLE.
  task automatic do_txn(input int port, input bit we, input logic [8:0] addr, input logic [31:0] wd);
    bit al;
    al = (addr[1:0] == 2'b00);
    sb.push_back(model(port, we, addr, wd));
    if (port == 0) begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    else begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    @(posedge clk); #1;
    chk("gnt_win", 32'(port == 0 ? p0_gnt : p1_gnt), 32'd1);
    chk("gnt_other", 32'(port == 0 ? p1_gnt : p0_gnt), 32'd0);
    chk("MemWrite", 32'(MemWrite), 32'(al && we));
    chk("MemRead", 32'(MemRead), 32'(al && !we));
    chk("mem_addr", 32'(mem_addr), 32'(addr));
    if (al && we) chk("mem_wdata", mem_wdata, wd);
    // Drop the request and scramble the inputs; the latched copy must be used.
    p0_req = 0; p1_req = 0; p0_addr = 9'($urandom); p1_addr = 9'($urandom);
    @(posedge clk); #1;
    chk("done_cycle2", 32'(port == 0 ? p0_done : p1_done), 32'd1);
    chk("strobe_resp", 32'(MemRead | MemWrite), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    // Preload both the memory and the model while in reset.
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      pl_en = 1; pl_idx = 7'(i);
      pl_val = (i == 5) ? 32'hDEADBEEF : (i == 0 ? 32'hA5A5_0000 : $urandom);
      ref_mem[i] = pl_val;
      @(negedge clk);
    end
    pl_en = 0;
    chk("rst_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    chk("rst_done", 32'({p0_done, p1_done, p0_err, p1_err}), 32'd0);
    chk("rst_strobe", 32'({MemRead, MemWrite}), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Directed cases.
    do_txn(0, 0, 9'h014, 32'h0);
    do_txn(1, 1, 9'h1FC, 32'h12345678);
    do_txn(1, 0, 9'h1FC, 32'h0);
    do_txn(0, 1, 9'h003, 32'hFFFFFFFF);
    do_txn(0, 0, 9'h000, 32'h0);
    chk("rdata_hold_p1", p1_rdata, 32'h12345678);

    // Random single-requester traffic with occasional misalignment and idle gaps.
    for (int n = 0; n < 60; n++) begin
      logic [8:0] a;
      a = {7'($urandom_range(0, 127)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during the CMD cycle of a read: outputs clear at once, no done follows.
    p0_req = 1; p0_we = 0; p0_addr = 9'h014;
    @(posedge clk); #1;
    p0_req = 0;
    #1 rst_n = 0;
    #1;
    chk("arst_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    chk("arst_strobe", 32'({MemRead, MemWrite}), 32'd0);
    chk("arst_maddr", 32'(mem_addr), 32'd0);
    chk("arst_rdata", p0_rdata | p1_rdata, 32'd0);
    chk("arst_done", 32'({p0_done, p1_done, p0_err, p1_err}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    do_txn(1, 0, 9'h014, 32'h0);

    // Contention: both ports hold requests; winners follow the tie-break rule.
    p0_req = 1; p0_we = 0; p0_addr = 9'h020;
    p1_req = 1; p1_we = 0; p1_addr = 9'h040;
    for (int k = 0; k < 6; k++) begin
      int w;
`ifdef DMEM_ARB_RR_EN
      w = k % 2;
`else
      w = 0;
`endif
      sb.push_back(model(w, 0, w == 0 ? 9'h020 : 9'h040, 32'h0));
      @(posedge clk); #1;
      chk("cont_gnt", 32'({p1_gnt, p0_gnt}), w == 0 ? 32'd1 : 32'd2);
      if (k == 5) begin p0_req = 0; p1_req = 0; end
      @(posedge clk);
      @(posedge clk);
    end
    @(negedge clk);

    // Idle stability: nothing moves without requests.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({p0_gnt, p1_gnt, p0_done, p1_done, MemRead, MemWrite}), 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
